scm_march_bist: RTL and testbench
=================================

Name: scm_march_bist

Overview:
- Built-in self-test controller for the latch-based 1R1W register file test wrapper.
- Sits directly upstream of the wrapper's test port and drives BIST, CSN_T, WEN_T, A_T, D_T and BE_T.
- Consumes Q_T and runs a March C- sequence over the full address space.
- Reports done/fail status, the first failing address/element and a saturating error count to the SoC test controller.

Parameters:
ADDR_WIDTH, 5, register file address width; depth N = 2**ADDR_WIDTH
DATA_WIDTH, 32, register file word width
NUM_BYTE, DATA_WIDTH/8, byte-enable width
READ_LATENCY, 1, cycles from a read issued on the test port to valid Q_T (>=1)
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  reset, synchronous, active-high
start  input  1  single-cycle pulse; sampled only in IDLE or DONE
busy  output  1  high from the cycle after start until done rises
done  output  1  sticky; cleared by rst or the next accepted start
fail  output  1  sticky; any read mismatch during the current run
fail_addr  output  ADDR_WIDTH  address of the first mismatch
fail_elem  output  3  March element index (0..5) of the first mismatch
err_count  output  ERR_CNT_WIDTH  mismatching reads, saturating at all-ones
BIST  output  1  test-mode select to the wrapper; high while busy
CSN_T  output  1  active-low chip select; 0 only on op cycles
WEN_T  output  1  0 = write, 1 = read; 1 when CSN_T = 1
A_T  output  ADDR_WIDTH  test address
D_T  output  DATA_WIDTH  write data: all-0 for w0, all-1 for w1; 0 otherwise
BE_T  output  NUM_BYTE  all-ones while BIST, else 0
Q_T  input  DATA_WIDTH  read data returned from the wrapper

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: BIST=0, CSN_T=1, WEN_T=1, A_T=0, D_T=0, BE_T=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, err_count=0. State goes to IDLE.
- Reset mid-run: aborts immediately and discards any in-flight compares; no partial status is retained.
- March C- elements:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 up(r0)
  - "up" runs addresses 0..N-1 and "down" runs N-1..0.
- Issue rate: one op per cycle. Two-op elements issue the read then the write to the same address on consecutive cycles, then advance the address.
- States: IDLE -> RUN (on start) -> GAP (after the last op of E0..E4, exactly 1 idle cycle with CSN_T=1, next element begins after it) -> RUN ... -> DRAIN (after the last E5 op) -> DONE.
  - DRAIN lasts READ_LATENCY cycles.
  - DONE -> RUN on start. That start clears fail, err_count, fail_addr, fail_elem and done.
- Timing, with start sampled at cycle 0:
  - First op (E0 w0 @0) at cycle 1.
  - Last op at cycle 10N+5.
  - done rises at cycle 10N+6+READ_LATENCY, which is 327 for the defaults.
  - busy falls in the same cycle done rises.
- Compare pipeline:
  - Each read pushes {valid, expected pattern, addr, elem} into a READ_LATENCY-deep shift register.
  - At the output stage, Q_T is compared against the all-0 or all-1 expectation over the full word.
  - On mismatch, err_count increments (saturating).
  - fail_addr and fail_elem are captured only if fail was 0. fail sets in the same cycle.
- start while busy: ignored. start in the same cycle as rst: rst wins.
- Wrap-around: the address counter never wraps inside an element; element termination is detected at the terminal address (N-1 up, 0 down) with the last op index.

Decomposition:
- Package scm_bist_pkg holds:
  - the state enum (IDLE, RUN, GAP, DRAIN, DONE);
  - the element table as constants (per element: direction, op count, op0/op1 kind, op0/op1 data value);
  - the NUM_ELEM=6 constant.
- Sub-module scm_bist_checker holds the READ_LATENCY compare pipeline, err_count saturation and first-fail capture. The top holds the FSM and address/op sequencing.

Test Plan:
- Fault-free wrapper model, defaults, start pulse at cycle 0 -> done=1 at cycle 327, fail=0, err_count=0, busy high for cycles 1..326, exactly 320 ops with CSN_T=0.
- Bit 7 of address 0x13 stuck-at-0 -> fail=1, fail_addr=0x13, fail_elem=2 (first r1), err_count=2 (E2, E4).
- Address decoder fault where a write to 0x04 also writes 0x05 -> fail=1, fail_addr=0x05, fail_elem=1, err_count>0.
- rst asserted at cycle 150 mid-E2 -> next cycle all outputs at reset values, BIST=0. A subsequent clean run passes.
- start pulses at cycles 0, 50 and 200 -> only the cycle-0 start is accepted, done still rises at cycle 327. A start after done clears done/fail and reruns.
- READ_LATENCY=2, ADDR_WIDTH=3 -> done at cycle 10*8+8=88, stuck fault at 0x7 gives fail_addr=0x7.

Source files
------------

// File: rtl/scm_bist_pkg.sv
// Shared types and the March C- element table for the register-file BIST.
package scm_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic {
        OP_R = 1'b0,
        OP_W = 1'b1
    } op_kind_t;

    typedef struct packed {
        logic     down;
        logic     two_op;
        op_kind_t op0;
        logic     d0;
        op_kind_t op1;
        logic     d1;
    } elem_t;

    localparam int NUM_ELEM = 6;

    // For read ops the data bit is the expected read-back value.
    localparam elem_t ELEM0 = '{down: 1'b0, two_op: 1'b0, op0: OP_W, d0: 1'b0, op1: OP_W, d1: 1'b0};
    localparam elem_t ELEM1 = '{down: 1'b0, two_op: 1'b1, op0: OP_R, d0: 1'b0, op1: OP_W, d1: 1'b1};
    localparam elem_t ELEM2 = '{down: 1'b0, two_op: 1'b1, op0: OP_R, d0: 1'b1, op1: OP_W, d1: 1'b0};
    localparam elem_t ELEM3 = '{down: 1'b1, two_op: 1'b1, op0: OP_R, d0: 1'b0, op1: OP_W, d1: 1'b1};
    localparam elem_t ELEM4 = '{down: 1'b1, two_op: 1'b1, op0: OP_R, d0: 1'b1, op1: OP_W, d1: 1'b0};
    localparam elem_t ELEM5 = '{down: 1'b0, two_op: 1'b0, op0: OP_R, d0: 1'b0, op1: OP_R, d1: 1'b0};

    function automatic elem_t elem_info(input logic [2:0] idx);
        case (idx)
            3'd0:    return ELEM0;
            3'd1:    return ELEM1;
            3'd2:    return ELEM2;
            3'd3:    return ELEM3;
            3'd4:    return ELEM4;
            default: return ELEM5;
        endcase
    endfunction

    function automatic logic elem_is_down(input logic [2:0] idx);
        elem_t e;
        e = elem_info(idx);
        return e.down;
    endfunction

    function automatic logic op_is_read(input elem_t e, input logic op);
        return ((op ? e.op1 : e.op0) == OP_R);
    endfunction

    function automatic logic op_data(input elem_t e, input logic op);
        return op ? e.d1 : e.d0;
    endfunction

    // Value driven on D_T: the pattern bit for writes, zero for reads.
    function automatic logic op_wbit(input elem_t e, input logic op);
        return !op_is_read(e, op) && op_data(e, op);
    endfunction

endpackage

// File: rtl/scm_bist_checker.sv
// Read-compare pipeline: aligns each issued read with Q_T, counts mismatches
// and latches the first failing address/element.
module scm_bist_checker #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_rd_valid,
    input  logic                     i_exp,
    input  logic [ADDR_WIDTH-1:0]    i_addr,
    input  logic [2:0]               i_elem,
    input  logic [DATA_WIDTH-1:0]    i_q,
    output logic                     o_fail,
    output logic [ADDR_WIDTH-1:0]    o_fail_addr,
    output logic [2:0]               o_fail_elem,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);
    typedef struct packed {
        logic                  valid;
        logic                  exp;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
    } stage_t;

    stage_t                   r_pipe [READ_LATENCY];
    logic                     r_fail;
    logic [ADDR_WIDTH-1:0]    r_fail_addr;
    logic [2:0]               r_fail_elem;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;
    logic                     w_mismatch;

    assign w_mismatch = r_pipe[READ_LATENCY-1].valid &&
                        (i_q != {DATA_WIDTH{r_pipe[READ_LATENCY-1].exp}});

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_err_count <= '0;
        end else begin
            r_pipe[0] <= '{valid: i_rd_valid, exp: i_exp, addr: i_addr, elem: i_elem};
            for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            if (w_mismatch) begin
                if (r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
                if (!r_fail) begin
                    r_fail      <= 1'b1;
                    r_fail_addr <= r_pipe[READ_LATENCY-1].addr;
                    r_fail_elem <= r_pipe[READ_LATENCY-1].elem;
                end
            end
        end
    end

    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_elem = r_fail_elem;
    assign o_err_count = r_err_count;

endmodule

// File: rtl/scm_march_bist.sv
// March C- BIST controller driving the register-file wrapper test port.
// States: IDLE wait start | RUN one op/cycle | GAP idle between elements | DRAIN wait compares | DONE status valid
module scm_march_bist
    import scm_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_BYTE      = DATA_WIDTH / 8,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic [2:0]               fail_elem,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     BIST,
    output logic                     CSN_T,
    output logic                     WEN_T,
    output logic [ADDR_WIDTH-1:0]    A_T,
    output logic [DATA_WIDTH-1:0]    D_T,
    output logic [NUM_BYTE-1:0]      BE_T,
    input  logic [DATA_WIDTH-1:0]    Q_T
);
    localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [DRAIN_W-1:0]    DRAIN_INIT = DRAIN_W'(READ_LATENCY - 1);

    state_t                r_state;
    logic [2:0]            r_elem;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_op;
    logic [DRAIN_W-1:0]    r_drain;
    logic                  r_bist;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_csn;
    logic                  r_wen;
    logic                  r_dval;

    elem_t                 w_cur;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_adv_addr;
    logic                  w_adv_op;
    logic                  w_nxt_down;
    logic                  w_start_ok;

    // Terminal address is N-1 going up and 0 going down; the counter never wraps.
    always_comb begin
        w_cur      = elem_info(r_elem);
        w_last     = (r_addr == {ADDR_WIDTH{~w_cur.down}}) && (!w_cur.two_op || r_op);
        w_adv_addr = r_addr;
        w_adv_op   = 1'b0;
        if (w_cur.two_op && !r_op) w_adv_op = 1'b1;
        else if (w_cur.down)       w_adv_addr = r_addr - ADDR_ONE;
        else                       w_adv_addr = r_addr + ADDR_ONE;
        w_nxt_down = elem_is_down(r_elem + 3'd1);
    end

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_elem  <= '0;
            r_addr  <= '0;
            r_op    <= 1'b0;
            r_drain <= '0;
            r_bist  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_csn   <= 1'b1;
            r_wen   <= 1'b1;
            r_dval  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_elem  <= '0;
                        r_addr  <= '0;
                        r_op    <= 1'b0;
                        r_bist  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_csn   <= 1'b0;
                        r_wen   <= op_is_read(ELEM0, 1'b0);
                        r_dval  <= op_wbit(ELEM0, 1'b0);
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_csn  <= 1'b1;
                        r_wen  <= 1'b1;
                        r_dval <= 1'b0;
                        if (r_elem == 3'(NUM_ELEM - 1)) begin
                            r_state <= ST_DRAIN;
                            r_drain <= DRAIN_INIT;
                        end else begin
                            r_state <= ST_GAP;
                            r_elem  <= r_elem + 3'd1;
                            r_addr  <= {ADDR_WIDTH{w_nxt_down}};
                            r_op    <= 1'b0;
                        end
                    end else begin
                        r_addr <= w_adv_addr;
                        r_op   <= w_adv_op;
                        r_csn  <= 1'b0;
                        r_wen  <= op_is_read(w_cur, w_adv_op);
                        r_dval <= op_wbit(w_cur, w_adv_op);
                    end
                end
                ST_GAP: begin
                    r_state <= ST_RUN;
                    r_csn   <= 1'b0;
                    r_wen   <= op_is_read(w_cur, 1'b0);
                    r_dval  <= op_wbit(w_cur, 1'b0);
                end
                ST_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_bist  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - DRAIN_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    scm_bist_checker #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .READ_LATENCY  (READ_LATENCY),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_checker (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_ok),
        .i_rd_valid  (~r_csn & r_wen),
        .i_exp       (op_data(w_cur, r_op)),
        .i_addr      (r_addr),
        .i_elem      (r_elem),
        .i_q         (Q_T),
        .o_fail      (fail),
        .o_fail_addr (fail_addr),
        .o_fail_elem (fail_elem),
        .o_err_count (err_count)
    );

    assign busy  = r_busy;
    assign done  = r_done;
    assign BIST  = r_bist;
    assign CSN_T = r_csn;
    assign WEN_T = r_wen;
    assign A_T   = r_addr;
    assign D_T   = {DATA_WIDTH{r_dval}};
    assign BE_T  = {NUM_BYTE{r_bist}};

endmodule

// File: tb/tb_scm_march_bist.sv
// Bench for scm_march_bist: two configurations against a faulty-memory model
// and a behavioural March C- reference.
module tb_scm_march_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    int   sel;

    logic        busy_a, done_a, fail_a, bist_a, csn_a, wen_a;
    logic [4:0]  faddr_a, a_a;
    logic [2:0]  felem_a;
    logic [7:0]  err_a;
    logic [31:0] d_a, q_a;
    logic [3:0]  be_a;

    logic        busy_b, done_b, fail_b, bist_b, csn_b, wen_b;
    logic [2:0]  faddr_b, a_b;
    logic [2:0]  felem_b;
    logic [7:0]  err_b;
    logic [31:0] d_b, q_b, qb0;
    logic [3:0]  be_b;

    scm_march_bist #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .READ_LATENCY(1), .ERR_CNT_WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start && sel == 0), .busy(busy_a), .done(done_a), .fail(fail_a),
        .fail_addr(faddr_a), .fail_elem(felem_a), .err_count(err_a), .BIST(bist_a), .CSN_T(csn_a),
        .WEN_T(wen_a), .A_T(a_a), .D_T(d_a), .BE_T(be_a), .Q_T(q_a));

    scm_march_bist #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .READ_LATENCY(2), .ERR_CNT_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start && sel == 1), .busy(busy_b), .done(done_b), .fail(fail_b),
        .fail_addr(faddr_b), .fail_elem(felem_b), .err_count(err_b), .BIST(bist_b), .CSN_T(csn_b),
        .WEN_T(wen_b), .A_T(a_b), .D_T(d_b), .BE_T(be_b), .Q_T(q_b));

    // Fault model: kind 1 = bit f_bit of address f_a reads as f_val;
    // kind 2 = a write to f_a also lands in f_b.
    int f_kind, f_a, f_b, f_bit;
    bit f_val;

    function automatic logic [31:0] rd_fault(input logic [31:0] v, input int addr);
        logic [31:0] r;
        r = v;
        if (f_kind == 1 && addr == f_a) r[f_bit] = f_val;
        return r;
    endfunction

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [8];

    always @(posedge clk) begin
        if (!csn_a && !wen_a) begin
            mem_a[a_a] <= d_a;
            if (f_kind == 2 && int'(a_a) == f_a) mem_a[f_b] <= d_a;
        end
        q_a <= rd_fault(mem_a[a_a], int'(a_a));
    end

    always @(posedge clk) begin
        if (!csn_b && !wen_b) begin
            mem_b[a_b] <= d_b;
            if (f_kind == 2 && int'(a_b) == f_a) mem_b[f_b[2:0]] <= d_b;
        end
        qb0 <= rd_fault(mem_b[a_b], int'(a_b));
        q_b <= qb0;
    end

    logic        g_busy, g_done, g_fail, g_bist, g_csn, g_wen;
    logic [4:0]  g_faddr, g_a;
    logic [2:0]  g_felem;
    logic [7:0]  g_err;
    logic [31:0] g_d;
    logic [3:0]  g_be;

    always_comb begin
        if (sel == 0) begin
            g_busy = busy_a; g_done = done_a; g_fail = fail_a; g_bist = bist_a;
            g_csn = csn_a; g_wen = wen_a; g_faddr = faddr_a; g_a = a_a;
            g_felem = felem_a; g_err = err_a; g_d = d_a; g_be = be_a;
        end else begin
            g_busy = busy_b; g_done = done_b; g_fail = fail_b; g_bist = bist_b;
            g_csn = csn_b; g_wen = wen_b; g_faddr = {2'b00, faddr_b}; g_a = {2'b00, a_b};
            g_felem = felem_b; g_err = err_b; g_d = d_b; g_be = be_b;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_zero"}, {g_busy, g_done, g_fail, g_faddr, g_felem, g_err, g_bist, g_a, g_d, g_be}, 0);
        check_eq({tag, "_csn_wen"}, {g_csn, g_wen}, 2'b11);
    endtask

    // March C- run over an n-word memory with the configured fault.
    task automatic ref_march(input int n, output bit rf, output int raddr, output int relem, output int rerr);
        logic [31:0] m [32];
        logic [31:0] v;
        int a;
        rf = 0; raddr = 0; relem = 0; rerr = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                a = (e == 3 || e == 4) ? n - 1 - k : k;
                if (e > 0) begin
                    v = rd_fault(m[a], a);
                    if (v !== {32{(e == 2 || e == 4)}}) begin
                        if (rerr < 255) rerr++;
                        if (!rf) begin rf = 1; raddr = a; relem = e; end
                    end
                end
                if (e < 5) begin
                    m[a] = {32{(e == 1 || e == 3)}};
                    if (f_kind == 2 && a == f_a) m[f_b] = {32{(e == 1 || e == 3)}};
                end
            end
        end
    endtask

    typedef struct {
        bit op;
        bit wr;
        int addr;
        bit val;
    } cyc_t;

    task automatic run_march(input int s, input bit spurious);
        int   n, rl, busy_n, ops, seq_err, done_rel, rerr, relem, raddr, sp1, sp2, a;
        bit   rf;
        cyc_t sched[$];
        cyc_t ex;
        n = (s == 0) ? 32 : 8;
        rl = (s == 0) ? 1 : 2;
        sp1 = (s == 0) ? 50 : 20;
        sp2 = (s == 0) ? 200 : 60;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                a = (e == 3 || e == 4) ? n - 1 - k : k;
                if (e > 0) begin ex.op = 1; ex.wr = 0; ex.addr = a; ex.val = 0; sched.push_back(ex); end
                if (e < 5) begin ex.op = 1; ex.wr = 1; ex.addr = a; ex.val = (e == 1 || e == 3); sched.push_back(ex); end
            end
            if (e < 5) begin ex = '{default: 0}; sched.push_back(ex); end
        end
        ref_march(n, rf, raddr, relem, rerr);
        busy_n = 0; ops = 0; seq_err = 0; done_rel = -1;

        @(negedge clk); sel = s; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_eq("start_clears", {g_done, g_fail, g_faddr, g_felem, g_err, ~g_busy}, 0);
        for (int rel = 1; rel < 10 * n + 100; rel++) begin
            start = spurious && (rel == sp1 || rel == sp2);
            if (g_busy) busy_n++;
            if (!g_csn) ops++;
            if (rel <= sched.size()) ex = sched[rel-1];
            else ex = '{default: 0};
            if (g_csn !== !ex.op) seq_err++;
            else if (ex.op && (g_wen !== !ex.wr || g_a !== 5'(ex.addr) ||
                               g_d !== ((ex.wr && ex.val) ? 32'hFFFF_FFFF : 32'h0))) seq_err++;
            if (g_bist !== g_busy || g_be !== {4{g_bist}}) seq_err++;
            if (g_done) begin done_rel = rel; break; end
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("done_cycle", done_rel, 10 * n + 6 + rl);
        check_eq("busy_cycles", busy_n, 10 * n + 5 + rl);
        check_eq("op_count", ops, 10 * n);
        check_eq("op_sequence_errs", seq_err, 0);
        check_eq("fail", g_fail, rf);
        check_eq("fail_addr", g_faddr, raddr);
        check_eq("fail_elem", g_felem, relem);
        check_eq("err_count", g_err, rerr);
        repeat (2) @(negedge clk);
        check_eq("done_sticky", {g_done, g_busy, g_bist, g_csn, g_be}, 8'b1001_0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; sel = 0;
        f_kind = 0; f_a = 0; f_b = 0; f_bit = 0; f_val = 0;
        repeat (3) @(negedge clk);
        check_reset("por_a");
        sel = 1; #1;
        check_reset("por_b");
        rst = 1'b0;

        run_march(0, 1'b1);

        f_kind = 1; f_a = 'h13; f_bit = 7; f_val = 1'b0;
        run_march(0, 1'b0);
        check_eq("stuck13_addr", g_faddr, 'h13);
        check_eq("stuck13_elem", g_felem, 2);
        check_eq("stuck13_err", g_err, 2);

        f_kind = 2; f_a = 4; f_b = 5;
        run_march(0, 1'b0);
        check_eq("couple45_addr", g_faddr, 5);
        check_eq("couple45_elem", g_felem, 1);
        check_eq("couple45_err_nonzero", g_err != 0, 1);

        f_kind = 0;
        run_march(0, 1'b0);

        // Mid-E2 reset with a compare for address 25 in flight at cycle 150.
        f_kind = 1; f_a = 25; f_bit = 3; f_val = 1'b0;
        @(negedge clk); sel = 0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (149) @(negedge clk);
        check_eq("pre_rst_fail", g_fail, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_discard", {g_fail, g_err, g_busy, g_done}, 0);
        f_kind = 0;
        run_march(0, 1'b0);

        run_march(1, 1'b1);
        f_kind = 1; f_a = 7; f_bit = $urandom_range(0, 31); f_val = 1'b0;
        run_march(1, 1'b0);
        check_eq("b_stuck7_addr", g_faddr, 7);

        for (int it = 0; it < 8; it++) begin
            int s, n;
            s = $urandom_range(0, 1);
            n = (s == 0) ? 32 : 8;
            f_kind = $urandom_range(0, 2);
            f_a = $urandom_range(0, n - 1);
            f_b = (f_a + 1 + $urandom_range(0, n - 2)) % n;
            f_bit = $urandom_range(0, 31);
            f_val = 1'($urandom_range(0, 1));
            run_march(s, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
